// File: rtl/m_xfer_engine.sv
// Source-to-destination FIFO transfer engine with a 2-entry skid buffer.
// Optional running checksum output enabled by defining M_XFER_CSUM_EN.
module m_xfer_engine (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        go,
    input  logic        abort,
    output logic        m_reset,
    output logic        m_src_getn,
    input  logic [63:0] m_src,
    input  logic        m_src_last,
    input  logic        m_src_empty,
    input  logic        m_src_almost_empty,
    output logic        m_dst_putn,
    output logic [63:0] m_dst,
    output logic        m_dst_last,
    input  logic        m_dst_full,
    input  logic        m_dst_almost_full,
    output logic        m_endn,
    output logic        busy,
    output logic        done,
`ifdef M_XFER_CSUM_EN
    output logic [31:0] csum,
`endif
    output logic [15:0] word_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [63:0] d0, d1;
    logic        l0, l1;
    logic [1:0]  cnt;
    logic        in_flight;
    logic        last_seen;
    logic [1:0]  occ;
    logic        start, push, pop, stop_pop;
    logic        unused_afull;

    assign unused_afull = m_dst_almost_full;

    // Occupancy counts the word leaving this cycle as already gone, so the
    // buffer can stream one word per cycle while never holding more than two.
    always_comb begin
        start    = go && !abort && (state_q != S_RUN);
        stop_pop = last_seen || (in_flight && m_src_last);
        push     = (state_q == S_RUN) && !abort && (cnt != 2'd0) && !m_dst_full;
        occ      = cnt + {1'b0, in_flight} - {1'b0, push};
        pop      = (state_q == S_RUN) && !abort && (occ < 2'd2) && !stop_pop
                   && !m_src_empty && !(in_flight && m_src_almost_empty);
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: if (go) state_d = S_RUN;
                S_RUN:          if (push && l0) state_d = S_DONE;
                default:        state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    assign busy       = (state_q == S_RUN);
    assign done       = (state_q == S_DONE);
    assign m_src_getn = !pop;
    assign m_dst_putn = !push;
    assign m_dst      = d0;
    assign m_dst_last = l0;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            d0        <= '0;
            d1        <= '0;
            l0        <= 1'b0;
            l1        <= 1'b0;
            cnt       <= 2'd0;
            in_flight <= 1'b0;
            last_seen <= 1'b0;
            word_cnt  <= '0;
            m_endn    <= 1'b1;
            m_reset   <= 1'b0;
`ifdef M_XFER_CSUM_EN
            csum      <= '0;
`endif
        end else begin
            m_reset <= abort;
            if (abort || start) begin
                d0        <= '0;
                l0        <= 1'b0;
                cnt       <= 2'd0;
                in_flight <= 1'b0;
                last_seen <= 1'b0;
                m_endn    <= 1'b1;
                if (start && !abort) word_cnt <= '0;
`ifdef M_XFER_CSUM_EN
                csum      <= '0;
`endif
            end else begin
                in_flight <= pop;
                if (in_flight && m_src_last) last_seen <= 1'b1;
                case ({push, in_flight})
                    2'b11: begin
                        if (cnt == 2'd1) begin
                            d0 <= m_src;
                            l0 <= m_src_last;
                        end else begin
                            d0 <= d1;
                            l0 <= l1;
                            d1 <= m_src;
                            l1 <= m_src_last;
                        end
                    end
                    2'b10: begin
                        d0  <= d1;
                        l0  <= l1;
                        cnt <= cnt - 2'd1;
                    end
                    2'b01: begin
                        if (cnt == 2'd0) begin
                            d0 <= m_src;
                            l0 <= m_src_last;
                        end else begin
                            d1 <= m_src;
                            l1 <= m_src_last;
                        end
                        cnt <= cnt + 2'd1;
                    end
                    default: ;
                endcase
                if (push) begin
                    word_cnt <= word_cnt + 16'd1;
                    if (l0) m_endn <= 1'b0;
`ifdef M_XFER_CSUM_EN
                    csum <= csum + d0[63:32] + d0[31:0];
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_m_xfer_engine.sv
// Directed self-checking bench for m_xfer_engine with behavioural source/dest FIFOs.
// Checksum step is compiled in only when M_XFER_CSUM_EN is defined.
module tb_m_xfer_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        go, abort;
    logic        m_reset, m_src_getn, m_dst_putn, m_dst_last, m_endn, busy, done;
    logic [63:0] m_src = '0;
    logic        m_src_last = 1'b0;
    logic        m_src_empty, m_src_almost_empty;
    logic [63:0] m_dst;
    logic        m_dst_full, m_dst_almost_full;
    logic [15:0] word_cnt;
`ifdef M_XFER_CSUM_EN
    logic [31:0] csum;
`endif

    always #5 clk = ~clk;

    m_xfer_engine dut (
        .wb_clk_i          (clk),
        .wb_rst_i          (rst),
        .go                (go),
        .abort             (abort),
        .m_reset           (m_reset),
        .m_src_getn        (m_src_getn),
        .m_src             (m_src),
        .m_src_last        (m_src_last),
        .m_src_empty       (m_src_empty),
        .m_src_almost_empty(m_src_almost_empty),
        .m_dst_putn        (m_dst_putn),
        .m_dst             (m_dst),
        .m_dst_last        (m_dst_last),
        .m_dst_full        (m_dst_full),
        .m_dst_almost_full (m_dst_almost_full),
        .m_endn            (m_endn),
        .busy              (busy),
        .done              (done),
`ifdef M_XFER_CSUM_EN
        .csum              (csum),
`endif
        .word_cnt          (word_cnt)
    );

    int          src_total = 0;
    int          src_rd = 0;
    logic        tab_mode = 1'b0;
    logic [63:0] tab [0:1];
    logic        clr = 1'b0;
    logic        pop_req = 1'b0;
    int          cyc = 0;

    int n_pop, n_push, n_order_err, n_full_err, n_empty_err, n_last, max_out, n_mreset;
    int pop_cyc, push_cyc;
    int n_tests = 0;
    int n_fail = 0;

    function automatic logic [63:0] word_at(input int i);
        if (tab_mode) return tab[i[0]];
        return 64'(i + 1);
    endfunction

    assign m_src_empty        = (src_rd >= src_total);
    assign m_src_almost_empty = (src_rd + 1 >= src_total);

    always @(posedge clk) cyc <= cyc + 1;

    // Source FIFO: data appears the cycle after a pop.
    always @(posedge clk) begin
        if (clr) begin
            src_rd <= 0;
        end else if (pop_req) begin
            m_src      <= word_at(src_rd);
            m_src_last <= (src_rd == src_total - 1);
            src_rd     <= src_rd + 1;
        end
    end

    // Monitor samples strobes mid-cycle; the FIFOs act on the following edge.
    always @(negedge clk) begin
        if (clr) begin
            n_pop = 0; n_push = 0; n_order_err = 0; n_full_err = 0;
            n_empty_err = 0; n_last = 0; max_out = 0; n_mreset = 0;
            pop_cyc = -1; push_cyc = -1;
        end else begin
            if (!m_src_getn) begin
                if (m_src_empty) n_empty_err++;
                if (n_pop == 0) pop_cyc = cyc;
                n_pop++;
            end
            if (!m_dst_putn) begin
                if (m_dst_full) n_full_err++;
                if (m_dst !== word_at(n_push) || m_dst_last !== (n_push == src_total - 1))
                    n_order_err++;
                if (m_dst_last) n_last++;
                if (n_push == 0) push_cyc = cyc;
                n_push++;
            end
            if (n_pop - n_push > max_out) max_out = n_pop - n_push;
            if (m_reset) n_mreset++;
        end
        pop_req <= !m_src_getn && !clr;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int total, input logic tm);
        @(posedge clk); #1;
        src_total = total;
        tab_mode  = tm;
        clr       = 1'b1;
        @(posedge clk); #1;
        clr       = 1'b0;
    endtask

    task automatic pulse_go();
        @(posedge clk); #1 go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int k = 0;
        while (!done && k < limit) begin
            @(posedge clk); #1;
            k++;
        end
        chk(tag, 64'(done), 64'd1);
    endtask

    task automatic wait_push(input string tag, input int n, input int limit);
        int k = 0;
        while (n_push < n && k < limit) begin
            @(posedge clk); #1;
            k++;
        end
        chk(tag, 64'(n_push >= n), 64'd1);
    endtask

    int pp, pu;

    initial begin
        tab[0] = {32'hFFFF_FFFF, 32'h0000_0001};
        tab[1] = {32'h0000_0002, 32'h0000_0003};
        rst = 1'b1; go = 1'b0; abort = 1'b0;
        m_dst_full = 1'b0; m_dst_almost_full = 1'b0;
        #2;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_getn", 64'(m_src_getn), 64'd1);
        chk("rst_putn", 64'(m_dst_putn), 64'd1);
        chk("rst_endn", 64'(m_endn), 64'd1);
        chk("rst_mreset", 64'(m_reset), 64'd0);
        chk("rst_wcnt", 64'(word_cnt), 64'd0);
        chk("rst_mdst", m_dst, 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Basic 4-word transfer
        load(4, 1'b0);
        pulse_go();
        chk("a_busy", 64'(busy), 64'd1);
        chk("a_endn_run", 64'(m_endn), 64'd1);
        wait_done("a_done", 100);
        chk("a_wcnt", 64'(word_cnt), 64'd4);
        chk("a_endn", 64'(m_endn), 64'd0);
        chk("a_busy_end", 64'(busy), 64'd0);
        chk("a_pushes", 64'(n_push), 64'd4);
        chk("a_order", 64'(n_order_err), 64'd0);
        chk("a_last", 64'(n_last), 64'd1);
        chk("a_empty", 64'(n_empty_err), 64'd0);

        // Destination full for 10 cycles mid-transfer, plus a go ignored during RUN
        load(4, 1'b0);
        pulse_go();
        chk("b_endn_go", 64'(m_endn), 64'd1);
        wait_push("b_wait2", 2, 50);
        m_dst_full = 1'b1;
        for (int i = 0; i < 10; i++) begin
            go = (i == 3);
            @(posedge clk); #1;
        end
        go = 1'b0;
        chk("b_stalled", 64'(n_push), 64'd2);
        chk("b_busy_stall", 64'(busy), 64'd1);
        m_dst_full = 1'b0;
        wait_done("b_done", 100);
        chk("b_fullpush", 64'(n_full_err), 64'd0);
        chk("b_pushes", 64'(n_push), 64'd4);
        chk("b_order", 64'(n_order_err), 64'd0);
        chk("b_held", 64'(max_out <= 2), 64'd1);
        chk("b_wcnt", 64'(word_cnt), 64'd4);

        // Single-word source
        load(1, 1'b0);
        pulse_go();
        wait_done("c_done", 50);
        repeat (4) @(posedge clk);
        #1;
        chk("c_pops", 64'(n_pop), 64'd1);
        chk("c_latency", 64'(push_cyc - pop_cyc), 64'd2);
        chk("c_wcnt", 64'(word_cnt), 64'd1);
        chk("c_empty", 64'(n_empty_err), 64'd0);

        // Abort after 2 of 8 words
        load(8, 1'b0);
        pulse_go();
        wait_push("d_wait2", 2, 50);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        pp = n_pop; pu = n_push;
        chk("d_pushes", 64'(n_push), 64'd2);
        chk("d_busy", 64'(busy), 64'd0);
        chk("d_done", 64'(done), 64'd0);
        chk("d_mreset_hi", 64'(m_reset), 64'd1);
        chk("d_endn", 64'(m_endn), 64'd1);
        @(posedge clk); #1;
        chk("d_mreset_lo", 64'(m_reset), 64'd0);
        repeat (8) @(posedge clk);
        #1;
        chk("d_nopop", 64'(n_pop), 64'(pp));
        chk("d_nopush", 64'(n_push), 64'(pu));
        chk("d_mreset_cnt", 64'(n_mreset), 64'd1);

        // Asynchronous reset mid-transfer
        load(8, 1'b0);
        pulse_go();
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("e_getn", 64'(m_src_getn), 64'd1);
        chk("e_putn", 64'(m_dst_putn), 64'd1);
        chk("e_busy", 64'(busy), 64'd0);
        chk("e_wcnt", 64'(word_cnt), 64'd0);
        chk("e_mdst", m_dst, 64'd0);
        chk("e_mdst_last", 64'(m_dst_last), 64'd0);
        chk("e_endn", 64'(m_endn), 64'd1);
        @(posedge clk); #1 rst = 1'b0;
        pp = n_pop; pu = n_push;
        repeat (5) @(posedge clk);
        #1;
        chk("e_idle_nopop", 64'(n_pop), 64'(pp));
        chk("e_idle_nopush", 64'(n_push), 64'(pu));
        chk("e_idle_busy", 64'(busy), 64'd0);

        // 65537 words: counter wraps to 1
        load(65537, 1'b0);
        pulse_go();
        wait_done("f_done", 70000);
        chk("f_wcnt", 64'(word_cnt), 64'd1);
        chk("f_pushes", 64'(n_push), 64'd65537);
        chk("f_order", 64'(n_order_err), 64'd0);
        chk("f_last", 64'(n_last), 64'd1);

`ifdef M_XFER_CSUM_EN
        load(2, 1'b1);
        pulse_go();
        chk("g_csum_clr", 64'(csum), 64'd0);
        wait_done("g_done", 50);
        chk("g_csum", 64'(csum), 64'h5);
        chk("g_order", 64'(n_order_err), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
